rs_alu_pipe: RTL

Parametrised integer ALU functional unit between the ALU reservation station and the common data bus (CDB) arbiter. It accepts one issued instruction per cycle under valid/ready, computes the result through a configurable-depth pipeline, and buffers results in a credit-protected queue until the CDB grants the bus. It is the successor to the single-cycle, unbuffered ALU unit: operands and results are no longer lost when the CDB is busy, and in-flight work can be flushed on mispredict.

---
 rtl/rs_alu_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rs_alu_pipe.sv
// rtl/rs_alu_pipe.sv - pipelined integer ALU unit with credit-protected CDB result queue
module rs_alu_pipe #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 6,
    parameter int OP_WIDTH  = 4,
    parameter int LATENCY   = 1,
    parameter int QDEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [OP_WIDTH-1:0]  issue_op_i,
    input  logic [XLEN-1:0]      issue_v1_i,
    input  logic [XLEN-1:0]      issue_v2_i,
    input  logic [TAG_WIDTH-1:0] issue_tag_i,
    input  logic                 flush_i,
    output logic                 cdb_req_o,
    input  logic                 cdb_gnt_i,
    output logic [XLEN-1:0]      cdb_value_o,
    output logic [TAG_WIDTH-1:0] cdb_tag_o
);

    localparam int SHW = $clog2(XLEN);
    localparam int PW  = $clog2(QDEPTH);
    localparam int CW  = $clog2(QDEPTH) + 1;
    localparam int OW  = $clog2(QDEPTH + LATENCY) + 1;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(9);

    logic                 issue_fire;
    logic                 fin_valid;
    logic [OP_WIDTH-1:0]  fin_op;
    logic [XLEN-1:0]      fin_a;
    logic [XLEN-1:0]      fin_b;
    logic [TAG_WIDTH-1:0] fin_tag;
    logic [OW-1:0]        stg_cnt;
    logic [XLEN-1:0]      result;
    logic [SHW-1:0]       shamt;

    assign issue_fire = issue_valid_i & issue_ready_o;

    // Final stage computes from the last register stage, or straight from the issue port when LATENCY is 1.
    generate
        if (LATENCY == 1) begin : g_direct
            assign fin_valid = issue_fire;
            assign fin_op    = issue_op_i;
            assign fin_a     = issue_v1_i;
            assign fin_b     = issue_v2_i;
            assign fin_tag   = issue_tag_i;
            assign stg_cnt   = '0;
        end else begin : g_pipe
            localparam int NSTG = LATENCY - 1;
            logic [NSTG-1:0]      vld;
            logic [OP_WIDTH-1:0]  op_q  [NSTG];
            logic [XLEN-1:0]      a_q   [NSTG];
            logic [XLEN-1:0]      b_q   [NSTG];
            logic [TAG_WIDTH-1:0] tag_q [NSTG];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld <= '0;
                end else if (flush_i) begin
                    vld <= '0;
                end else begin
                    vld[0] <= issue_fire;
                    for (int s = 1; s < NSTG; s++) vld[s] <= vld[s-1];
                end
            end

            always_ff @(posedge clk) begin
                op_q[0]  <= issue_op_i;
                a_q[0]   <= issue_v1_i;
                b_q[0]   <= issue_v2_i;
                tag_q[0] <= issue_tag_i;
                for (int s = 1; s < NSTG; s++) begin
                    op_q[s]  <= op_q[s-1];
                    a_q[s]   <= a_q[s-1];
                    b_q[s]   <= b_q[s-1];
                    tag_q[s] <= tag_q[s-1];
                end
            end

            always_comb begin
                stg_cnt = '0;
                for (int s = 0; s < NSTG; s++) stg_cnt = stg_cnt + OW'(vld[s]);
            end

            assign fin_valid = vld[NSTG-1];
            assign fin_op    = op_q[NSTG-1];
            assign fin_a     = a_q[NSTG-1];
            assign fin_b     = b_q[NSTG-1];
            assign fin_tag   = tag_q[NSTG-1];
        end
    endgenerate

    assign shamt = fin_b[SHW-1:0];

    always_comb begin
        result = '0;
        case (fin_op)
            OP_ADD:  result = fin_a + fin_b;
            OP_SUB:  result = fin_a - fin_b;
            OP_SLL:  result = fin_a << shamt;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(fin_a) < $signed(fin_b))};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, (fin_a < fin_b)};
            OP_XOR:  result = fin_a ^ fin_b;
            OP_SRL:  result = fin_a >> shamt;
            OP_SRA:  result = $unsigned($signed(fin_a) >>> shamt);
            OP_OR:   result = fin_a | fin_b;
            OP_AND:  result = fin_a & fin_b;
            default: result = '0;
        endcase
    end

    logic [XLEN-1:0]      val_mem [QDEPTH];
    logic [TAG_WIDTH-1:0] tag_mem [QDEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 push;
    logic                 pop;
    logic [OW-1:0]        occ;

    assign push = fin_valid & ~flush_i;
    assign pop  = cdb_req_o & cdb_gnt_i & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // At full, a push lands in the slot being popped this cycle; the head is read before the edge.
    always_ff @(posedge clk) begin
        if (push) begin
            val_mem[wr_ptr] <= result;
            tag_mem[wr_ptr] <= fin_tag;
        end
    end

    assign cdb_req_o   = (count != '0);
    assign cdb_value_o = cdb_req_o ? val_mem[rd_ptr] : '0;
    assign cdb_tag_o   = cdb_req_o ? tag_mem[rd_ptr] : '0;

    // Credit counts in-flight stages so every accepted issue has a reserved queue slot.
    assign occ           = OW'(count) + stg_cnt;
    assign issue_ready_o = (occ < OW'(QDEPTH)) & ~flush_i;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == CW'(QDEPTH))));

endmodule
